// File: rtl/add_mul_pkg.sv
// Shared types for the add/mul sharing controller.
// Operand width, operation codes and controller FSM states.
package add_mul_pkg;

  localparam int ADDMUL_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } ctrl_state_e;

endpackage

// File: rtl/add_mul_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from the valids.
// The pointer moves to the losing side on every advance strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_valid)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_adv) begin
      r_ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/add_mul_share_ctrl.sv
// Two-requester controller for a shared 4-bit add/mul unit.
// Define ADDMUL_PERF_CNT_EN to build saturating per-requester grant counters.
module add_mul_share_ctrl
  import add_mul_pkg::*;
#(
  parameter int W     = ADDMUL_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [2*W-1:0]   rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [2*W-1:0]   rsp1_data,
  output logic [W-1:0]     dp_a,
  output logic [W-1:0]     dp_b,
  input  logic [2*W-1:0]   dp_mul,
  input  logic [W-1:0]     dp_add,
  output logic [CNT_W-1:0] perf_grant0,
  output logic [CNT_W-1:0] perf_grant1
);

  ctrl_state_e      r_state;
  op_e              r_op;
  logic             r_id;
  logic [W-1:0]     r_dp_a;
  logic [W-1:0]     r_dp_b;
  logic             r_rsp_valid;
  logic [2*W-1:0]   r_rsp_data;

  logic [1:0]       w_gnt;
  logic             w_idle;
  logic             w_accept;
  logic             w_rsp_ready;
  op_e              w_sel_op;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid ({req1_valid, req0_valid}),
    .i_adv   (w_accept),
    .o_gnt   (w_gnt)
  );

  assign w_idle     = (r_state == IDLE);
  assign w_accept   = w_idle & (|w_gnt);
  assign req0_ready = w_idle & w_gnt[0];
  assign req1_ready = w_idle & w_gnt[1];

  always_comb begin
    w_sel_op = op_e'(req0_op);
    w_sel_a  = req0_a;
    w_sel_b  = req0_b;
    if (w_gnt[1]) begin
      w_sel_op = op_e'(req1_op);
      w_sel_a  = req1_a;
      w_sel_b  = req1_b;
    end
  end

  assign w_rsp_ready = r_id ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_ADD;
      r_id        <= 1'b0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id    <= w_gnt[1];
            r_op    <= w_sel_op;
            r_dp_a  <= w_sel_a;
            r_dp_b  <= w_sel_b;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          // add result wraps to W bits; the carry is deliberately lost
          r_rsp_data  <= (r_op == OP_MUL) ? dp_mul : {{W{1'b0}}, dp_add};
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (w_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dp_a       = r_dp_a;
  assign dp_b       = r_dp_b;
  assign rsp0_valid = r_rsp_valid & ~r_id;
  assign rsp1_valid = r_rsp_valid & r_id;
  assign rsp0_data  = r_id ? '0 : r_rsp_data;
  assign rsp1_data  = r_id ? r_rsp_data : '0;

`ifdef ADDMUL_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf0;
  logic [CNT_W-1:0] r_perf1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf0 <= '0;
      r_perf1 <= '0;
    end else begin
      if (w_accept && w_gnt[0] && (r_perf0 != '1))
        r_perf0 <= r_perf0 + CNT_W'(1);
      if (w_accept && w_gnt[1] && (r_perf1 != '1))
        r_perf1 <= r_perf1 + CNT_W'(1);
    end
  end

  assign perf_grant0 = r_perf0;
  assign perf_grant1 = r_perf1;
`else
  assign perf_grant0 = '0;
  assign perf_grant1 = '0;
`endif

endmodule
